// File: rtl/dmem_responder.sv
// Data-memory slave for the core's load/store port: accepts one request,
// executes it on a word array, and returns the response after latency_p cycles.
module dmem_responder #(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        wen_i,
    input  logic        byte_not_word_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    input  logic        yumi_i,
    output logic        yumi_o,
    output logic        valid_o,
    output logic [31:0] read_data_o,
    output logic        err_o
);

    if (latency_p < 1 || latency_p > 15) begin : g_bad_latency
        $fatal(1, "dmem_responder: latency_p must be within 1..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic [31:0] mem [2**addr_width_p];

    logic [addr_width_p-1:0] idx;
    logic [1:0]              lane;
    logic [31:0]             old_word;
    logic [31:0]             merged_word;
    logic [31:0]             store_word;
    logic [31:0]             load_word;
    logic                    addr_err;
    logic                    accept;

    assign idx      = addr_i[2 +: addr_width_p];
    assign lane     = addr_i[1:0];
    assign old_word = mem[idx];

    // Byte stores merge into the current word so the response carries the full post-merge value.
    always_comb begin
        merged_word = old_word;
        merged_word[{lane, 3'b000} +: 8] = write_data_i[7:0];
    end

    assign store_word = byte_not_word_i ? merged_word : write_data_i;
    assign load_word  = byte_not_word_i ? {24'h0, old_word[{lane, 3'b000} +: 8]} : old_word;
    assign addr_err   = (addr_i[31:addr_width_p+2] != '0) || (!byte_not_word_i && (lane != 2'b00));

    assign accept  = reset && valid_i && (state_q == IDLE);
    assign yumi_o  = accept;
    assign valid_o = (state_q == RESP);
    assign read_data_o = data_q;
    assign err_o   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d = wen_i ? store_word : load_word;
                    err_d  = err_q | addr_err;
                    cnt_d  = 4'(latency_p - 1);
                    state_d = (latency_p == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // The array survives reset; only accepted stores modify it.
    always_ff @(posedge clk) begin
        if (accept && wen_i) begin
            mem[idx] <= store_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 2, 1, 4) checked against
// a word-array reference model built from the load/store rules.
module tb_dmem_responder;

    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        valid_i [3];
    logic        wen_i   [3];
    logic        bnw_i   [3];
    logic        yumi_i  [3];
    logic [31:0] addr_i  [3];
    logic [31:0] wdata_i [3];
    logic        yumi_o  [3];
    logic        valid_o [3];
    logic        err_o   [3];
    logic [31:0] rdata_o [3];

    dmem_responder #(.addr_width_p(AW), .latency_p(2)) u_lat2 (
        .clk(clk), .reset(reset), .valid_i(valid_i[0]), .wen_i(wen_i[0]),
        .byte_not_word_i(bnw_i[0]), .addr_i(addr_i[0]), .write_data_i(wdata_i[0]),
        .yumi_i(yumi_i[0]), .yumi_o(yumi_o[0]), .valid_o(valid_o[0]),
        .read_data_o(rdata_o[0]), .err_o(err_o[0]));

    dmem_responder #(.addr_width_p(AW), .latency_p(1)) u_lat1 (
        .clk(clk), .reset(reset), .valid_i(valid_i[1]), .wen_i(wen_i[1]),
        .byte_not_word_i(bnw_i[1]), .addr_i(addr_i[1]), .write_data_i(wdata_i[1]),
        .yumi_i(yumi_i[1]), .yumi_o(yumi_o[1]), .valid_o(valid_o[1]),
        .read_data_o(rdata_o[1]), .err_o(err_o[1]));

    dmem_responder #(.addr_width_p(AW), .latency_p(4)) u_lat4 (
        .clk(clk), .reset(reset), .valid_i(valid_i[2]), .wen_i(wen_i[2]),
        .byte_not_word_i(bnw_i[2]), .addr_i(addr_i[2]), .write_data_i(wdata_i[2]),
        .yumi_i(yumi_i[2]), .yumi_o(yumi_o[2]), .valid_o(valid_o[2]),
        .read_data_o(rdata_o[2]), .err_o(err_o[2]));

    bit [31:0] mdl   [3][1024];
    bit        known [3][1024];
    bit        err_m [3];
    int        pass_cnt = 0;
    int        total_cnt = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    // Reference behaviour: returns the response word and updates the model array/error flag.
    function automatic logic [31:0] model_access(input int d, input bit wen, input bit bnw,
                                                 input logic [31:0] addr, input logic [31:0] wdata);
        int          idx;
        int          sh;
        logic [31:0] old;
        logic [31:0] neu;
        idx = int'(addr[11:2]);
        sh  = 8 * int'(addr[1:0]);
        old = mdl[d][idx];
        if ((addr >> 12) != 0 || (!bnw && addr[1:0] != 2'b00)) err_m[d] = 1'b1;
        if (wen) begin
            if (bnw) neu = (old & ~(32'hFF << sh)) | ({24'h0, wdata[7:0]} << sh);
            else     neu = wdata;
            mdl[d][idx] = neu;
            if (!bnw) known[d][idx] = 1'b1;
            return neu;
        end
        return bnw ? ((old >> sh) & 32'hFF) : old;
    endfunction

    task automatic xact(input int d, input bit wen, input bit bnw,
                        input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp;
        int          n;
        exp = model_access(d, wen, bnw, addr, wdata);
        @(negedge clk);
        valid_i[d] = 1'b1; wen_i[d] = wen; bnw_i[d] = bnw;
        addr_i[d] = addr; wdata_i[d] = wdata; yumi_i[d] = 1'b0;
        #1;
        total_cnt++;
        if (yumi_o[d] !== 1'b1) $display("FAIL yumi_req d%0d: got %b want 1", d, yumi_o[d]);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        valid_i[d] = 1'b0;
        total_cnt++;
        if (err_o[d] !== err_m[d]) $display("FAIL err d%0d addr %h: got %b want %b", d, addr, err_o[d], err_m[d]);
        else pass_cnt++;
        n = 1;
        while (valid_o[d] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (n != lat_of(d)) $display("FAIL latency d%0d: got %0d want %0d", d, n, lat_of(d));
        else pass_cnt++;
        total_cnt++;
        if (rdata_o[d] !== exp) $display("FAIL rdata d%0d addr %h: got %h want %h", d, addr, rdata_o[d], exp);
        else pass_cnt++;
        yumi_i[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        yumi_i[d] = 1'b0;
        total_cnt++;
        if (valid_o[d] !== 1'b0 || rdata_o[d] !== exp)
            $display("FAIL after_ack d%0d: got valid %b data %h want valid 0 data %h", d, valid_o[d], rdata_o[d], exp);
        else pass_cnt++;
        $display("xact d%0d %s%s addr=%h wdata=%h -> data=%h lat=%0d err=%b",
                 d, wen ? "S" : "L", bnw ? "B" : "W", addr, wdata, rdata_o[d], n, err_o[d]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int d = 0; d < 3; d++) err_m[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int d = 0; d < 3; d++) valid_i[d] = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                total_cnt++;
                if (yumi_o[d] !== 1'b0 || valid_o[d] !== 1'b0 || rdata_o[d] !== 32'h0 || err_o[d] !== 1'b0)
                    $display("FAIL reset_state d%0d: got yumi %b valid %b data %h err %b want 0 0 0 0",
                             d, yumi_o[d], valid_o[d], rdata_o[d], err_o[d]);
                else pass_cnt++;
            end
        end
        for (int d = 0; d < 3; d++) valid_i[d] = 1'b0;
        reset = 1'b1;
        $display("reset: outputs checked on all instances");
    endtask

    task automatic test_word();
        xact(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        xact(0, 1'b0, 1'b0, 32'h10, 32'h0);
    endtask

    task automatic test_byte();
        xact(0, 1'b1, 1'b1, 32'h12, 32'h00000055);
        xact(0, 1'b0, 1'b0, 32'h10, 32'h0);
        xact(0, 1'b0, 1'b1, 32'h13, 32'h0);
        xact(0, 1'b0, 1'b1, 32'h12, 32'h0);
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp1;
        logic [31:0] exp2;
        int          n;
        exp1 = model_access(0, 1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        valid_i[0] = 1'b1; wen_i[0] = 1'b0; bnw_i[0] = 1'b0; addr_i[0] = 32'h10; yumi_i[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        valid_i[0] = 1'b0;
        n = 1;
        while (valid_o[0] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (n != 2) $display("FAIL bp_latency: got %0d want 2", n);
        else pass_cnt++;
        // A second request (LBU 0x12) waits while the response is held.
        valid_i[0] = 1'b1; bnw_i[0] = 1'b1; addr_i[0] = 32'h12;
        for (int c = 0; c < 5; c++) begin
            #1;
            total_cnt++;
            if (valid_o[0] !== 1'b1 || rdata_o[0] !== exp1 || yumi_o[0] !== 1'b0)
                $display("FAIL bp_hold cyc%0d: got valid %b data %h yumi %b want 1 %h 0",
                         c, valid_o[0], rdata_o[0], yumi_o[0], exp1);
            else pass_cnt++;
            @(negedge clk);
        end
        yumi_i[0] = 1'b1;
        #1;
        total_cnt++;
        if (yumi_o[0] !== 1'b0) $display("FAIL bp_yumi_in_ack: got %b want 0", yumi_o[0]);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        yumi_i[0] = 1'b0;
        #1;
        total_cnt++;
        if (yumi_o[0] !== 1'b1 || valid_o[0] !== 1'b0)
            $display("FAIL bp_next_accept: got yumi %b valid %b want 1 0", yumi_o[0], valid_o[0]);
        else pass_cnt++;
        exp2 = model_access(0, 1'b0, 1'b1, 32'h12, 32'h0);
        @(posedge clk);
        @(negedge clk);
        valid_i[0] = 1'b0;
        n = 1;
        while (valid_o[0] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (n != 2 || rdata_o[0] !== exp2)
            $display("FAIL bp_second: got lat %0d data %h want 2 %h", n, rdata_o[0], exp2);
        else pass_cnt++;
        yumi_i[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        yumi_i[0] = 1'b0;
        $display("back_pressure: held data=%h, second data=%h", exp1, exp2);
    endtask

    task automatic test_throughput(input int d);
        int          acc [$];
        int          lat;
        lat = lat_of(d);
        mdl[d][32'h20] = 32'hA5A5_0000 + d;
        known[d][32'h20] = 1'b1;
        @(negedge clk);
        valid_i[d] = 1'b1; wen_i[d] = 1'b1; bnw_i[d] = 1'b0;
        addr_i[d] = 32'h80; wdata_i[d] = 32'hA5A5_0000 + d; yumi_i[d] = 1'b1;
        for (int c = 0; c < 4 * (lat + 1) + 1; c++) begin
            #1;
            if (yumi_o[d] === 1'b1) acc.push_back(c);
            @(negedge clk);
        end
        valid_i[d] = 1'b0;
        for (int c = 0; c < lat + 3; c++) @(negedge clk);
        yumi_i[d] = 1'b0;
        total_cnt++;
        if (acc.size() < 4) $display("FAIL tput_count d%0d: got %0d accepts want >=4", d, acc.size());
        else pass_cnt++;
        for (int i = 1; i < acc.size(); i++) begin
            total_cnt++;
            if (acc[i] - acc[i-1] != lat + 1)
                $display("FAIL tput_interval d%0d: got %0d want %0d", d, acc[i] - acc[i-1], lat + 1);
            else pass_cnt++;
        end
        $display("throughput d%0d: %0d accepts, period %0d", d, acc.size(), lat + 1);
    endtask

    task automatic test_latency();
        xact(1, 1'b1, 1'b0, 32'h40, 32'h0BAD_F00D);
        xact(1, 1'b0, 1'b1, 32'h41, 32'h0);
        xact(2, 1'b1, 1'b0, 32'h44, 32'h1357_9BDF);
        xact(2, 1'b0, 1'b0, 32'h44, 32'h0);
        test_throughput(1);
        test_throughput(2);
    endtask

    task automatic test_errors();
        xact(0, 1'b1, 1'b0, 32'h0, 32'h1234_5678);
        xact(0, 1'b0, 1'b0, 32'h1002, 32'h0);
        xact(0, 1'b0, 1'b0, 32'h10, 32'h0);
        xact(0, 1'b0, 1'b0, 32'h4000, 32'h0);
        do_reset();
        total_cnt++;
        if (err_o[0] !== 1'b0) $display("FAIL err_clear: got %b want 0", err_o[0]);
        else pass_cnt++;
        xact(0, 1'b0, 1'b0, 32'h4000, 32'h0);
        do_reset();
    endtask

    task automatic test_reset_wait();
        @(negedge clk);
        valid_i[0] = 1'b1; wen_i[0] = 1'b0; bnw_i[0] = 1'b0; addr_i[0] = 32'h10; yumi_i[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (valid_o[0] !== 1'b0) $display("FAIL rw_wait_state: got valid %b want 0", valid_o[0]);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (yumi_o[0] !== 1'b0) $display("FAIL rw_yumi_in_reset: got %b want 0", yumi_o[0]);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (valid_o[0] !== 1'b0 || rdata_o[0] !== 32'h0 || err_o[0] !== 1'b0)
            $display("FAIL rw_after_reset: got valid %b data %h err %b want 0 0 0", valid_o[0], rdata_o[0], err_o[0]);
        else pass_cnt++;
        reset = 1'b1;
        valid_i[0] = 1'b0;
        for (int d = 0; d < 3; d++) err_m[d] = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (valid_o[0] !== 1'b0) $display("FAIL rw_abandoned: got valid %b want 0", valid_o[0]);
        else pass_cnt++;
        $display("reset_during_wait: pending load abandoned");
        xact(0, 1'b0, 1'b0, 32'h10, 32'h0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int          d;
            int          w;
            bit          wen;
            bit          bnw;
            logic [31:0] addr;
            d   = int'($urandom_range(0, 2));
            w   = int'($urandom_range(0, 31));
            wen = ($urandom_range(0, 1) == 1);
            bnw = ($urandom_range(0, 1) == 1);
            if (!known[d][w]) begin
                wen = 1'b1;
                bnw = 1'b0;
            end
            addr = {20'h0, w[9:0], 2'b00};
            if (bnw || $urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = addr | 32'h0001_0000;
            xact(d, wen, bnw, addr, $urandom);
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            valid_i[d] = 1'b0; wen_i[d] = 1'b0; bnw_i[d] = 1'b0; yumi_i[d] = 1'b0;
            addr_i[d] = 32'h0; wdata_i[d] = 32'h0; err_m[d] = 1'b0;
        end
        test_reset();
        test_word();
        test_byte();
        test_back_pressure();
        test_latency();
        test_errors();
        test_reset_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
